// File: rtl/sugar_frame_tx_pkg.sv
// Shared constants, state encoding and frame byte lookup for the sugar reading frame transmitter.
package sugar_frame_tx_pkg;

    localparam logic [7:0] AsciiZero = 8'h30;
    localparam logic [7:0] AsciiDot  = 8'h2E;
    localparam logic [7:0] AsciiCr   = 8'h0D;
    localparam logic [7:0] AsciiLf   = 8'h0A;
    localparam int unsigned FrameLen = 7;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StSend,
        StWaitAck,
        StWaitDone
    } state_e;

    // Frame layout "DDD.D\r\n": bcd[15:12] is the hundreds digit.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [15:0] bcd);
        logic [7:0] b;
        b = AsciiLf;
        case (idx)
            3'd0:    b = AsciiZero + {4'h0, bcd[15:12]};
            3'd1:    b = AsciiZero + {4'h0, bcd[11:8]};
            3'd2:    b = AsciiZero + {4'h0, bcd[7:4]};
            3'd3:    b = AsciiDot;
            3'd4:    b = AsciiZero + {4'h0, bcd[3:0]};
            3'd5:    b = AsciiCr;
            default: b = AsciiLf;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sugar_frame_tx_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, the first shift folded into the load.
module bin2bcd_seq #(
    parameter int unsigned DATA_W = 14
) (
    input  logic              clk_50m,
    input  logic              start,
    input  logic              go,
    input  logic [DATA_W-1:0] bin,
    output logic              done,
    output logic [15:0]       bcd
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sr_q;
    logic [15:0]       bcd_q;
    logic [15:0]       adj;
    logic [CntW-1:0]   cnt_q;
    logic              running_q;
    logic              done_q;
    logic              unused_adj_msb;

    always_comb begin
        adj = '0;
        for (int i = 0; i < 4; i++) begin
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end
    end

    assign unused_adj_msb = adj[15];

    always_ff @(posedge clk_50m) begin
        if (!start) begin
            sr_q      <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (go) begin
                // BCD starts at zero, so the add-3 step of the first shift is a no-op.
                sr_q      <= {bin[DATA_W-2:0], 1'b0};
                bcd_q     <= {15'd0, bin[DATA_W-1]};
                cnt_q     <= CntW'(DATA_W - 1);
                running_q <= 1'b1;
            end else if (running_q) begin
                bcd_q <= {adj[14:0], sr_q[DATA_W-1]};
                sr_q  <= {sr_q[DATA_W-2:0], 1'b0};
                cnt_q <= cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/sugar_frame_tx.sv
// Converts one Brix x10 reading to BCD and sends it as "DDD.D\r\n" over the UART byte handshake.
module sugar_frame_tx
    import sugar_frame_tx_pkg::*;
#(
    parameter int unsigned DATA_W  = 14,
    parameter int unsigned SAT_VAL = 9999
) (
    input  logic              clk_50m,
    input  logic              start,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    input  logic              tx_data_ready,
    output logic [7:0]        tx_data,
    output logic              tx_data_valid,
    output logic              busy,
    output logic              sat_flag,
    output logic              sample_dropped
);

    localparam logic [DATA_W-1:0] SatVal = DATA_W'(SAT_VAL);

    state_e            state_q;
    logic [2:0]        idx_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              sat_q;
    logic              dropped_q;
    logic              over_sat;
    logic [DATA_W-1:0] bin_clamped;
    logic              conv_go;
    logic              conv_done;
    logic [15:0]       bcd;

    assign over_sat    = sample_data > SatVal;
    assign bin_clamped = over_sat ? SatVal : sample_data;
    assign conv_go     = (state_q == StIdle) && sample_valid;

    bin2bcd_seq #(
        .DATA_W (DATA_W)
    ) u_bin2bcd (
        .clk_50m (clk_50m),
        .start   (start),
        .go      (conv_go),
        .bin     (bin_clamped),
        .done    (conv_done),
        .bcd     (bcd)
    );

    always_ff @(posedge clk_50m) begin
        if (!start) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            sat_q      <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            // Includes the cycle busy falls: IDLE only accepts from the next cycle on.
            dropped_q  <= sample_valid && (state_q != StIdle);
            case (state_q)
                StIdle: begin
                    if (sample_valid) begin
                        sat_q   <= over_sat;
                        busy_q  <= 1'b1;
                        state_q <= StConv;
                    end
                end
                StConv: begin
                    if (conv_done) begin
                        idx_q   <= '0;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (tx_data_ready) begin
                        tx_data_q  <= frame_byte(idx_q, bcd);
                        tx_valid_q <= 1'b1;
                        state_q    <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (!tx_data_ready) begin
                        state_q <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (tx_data_ready) begin
                        if (idx_q == 3'(FrameLen - 1)) begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= StSend;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_data        = tx_data_q;
    assign tx_data_valid  = tx_valid_q;
    assign busy           = busy_q;
    assign sat_flag       = sat_q;
    assign sample_dropped = dropped_q;

endmodule

// File: doc/sugar_frame_tx.md
Name: sugar_frame_tx

Overview:
Upstream feeder for the byte-level UART transmitter. Takes one sugar reading (Brix x10, unsigned binary) per sample_valid pulse and converts it to four BCD digits. Emits a fixed 7-byte ASCII frame "DDD.D\r\n" one byte at a time over the transmitter's tx_data / tx_data_valid / tx_data_ready handshake. Sits between the measurement/scaling logic and the UART transmitter, in the clk_50m domain.

Parameters:
DATA_W, 14, width of sample_data.
SAT_VAL, 9999, largest value printable; larger inputs clamp to this.

Ports:
clk_50m  input  1  system clock, 50 MHz.
start  input  1  reset; synchronous, active-low (sampled on rising clk_50m).
sample_data  input  DATA_W  reading in Brix x10 (1234 = 123.4).
sample_valid  input  1  one-cycle pulse; sample_data is valid this cycle.
tx_data_ready  input  1  from UART transmitter; high = idle and able to accept.
tx_data  output  8  byte to transmit.
tx_data_valid  output  1  one-cycle request to the transmitter.
busy  output  1  high from sample capture until the last byte's stop bit completes.
sat_flag  output  1  sticky per frame; high if the current/last sample was clamped.
sample_dropped  output  1  one-cycle pulse when sample_valid arrives while busy.

Behaviour:
- Reset (start=0 at clock edge): state IDLE; tx_data=8'h00, tx_data_valid=0, busy=0, sat_flag=0, sample_dropped=0; BCD and byte index cleared. Reset mid-frame abandons the frame immediately; no further tx_data_valid.
- IDLE: on sample_valid, capture min(sample_data, SAT_VAL); sat_flag <= (sample_data > SAT_VAL); busy <= 1; go CONV.
- CONV: sequential double-dabble in bin2bcd_seq, one shift per cycle, DATA_W cycles. Digits d3..d0 ready DATA_W+1 cycles after capture; go SEND with byte index 0.
- Frame bytes by index 0..6: d3, d2, d1, 8'h2E '.', d0, 8'h0D, 8'h0A. Digit byte = 8'h30 + BCD nibble. No leading-zero suppression.
- SEND: wait for tx_data_ready=1. On that cycle drive tx_data for the current index and pulse tx_data_valid for exactly one cycle; go WAIT_ACK.
- WAIT_ACK: wait for tx_data_ready=0 (transmitter accepted), then go WAIT_DONE. tx_data held stable.
- WAIT_DONE: wait for tx_data_ready=1. If index=6, go IDLE and set busy <= 0 that cycle. Otherwise increment the index and go SEND; the next valid is issued on the following cycle.
- tx_data_valid is never high outside SEND and never on two consecutive cycles. This prevents a held valid from retriggering the transmitter when it re-enters idle.
- sample_valid while busy=1: ignored and pulses sample_dropped for one cycle. A sample arriving in the same cycle busy falls is also dropped; IDLE accepts only from the following cycle.
- sat_flag holds until the next accepted sample.
- Latency from sample_valid to first tx_data_valid: DATA_W+2 cycles when tx_data_ready is already high.

Decomposition:
- Shared package: frame byte constants (ASCII '0' 8'h30, '.' 8'h2E, CR 8'h0D, LF 8'h0A), FRAME_LEN=7, and state encodings IDLE, CONV, SEND, WAIT_ACK, WAIT_DONE.
- Sub-module bin2bcd_seq (ports: clk_50m, start, go, bin[DATA_W-1:0], done, bcd[15:0]) does the iterative add-3/shift conversion.
- The frame FSM and byte mux stay in the top level.

Test Plan:
- Sample 1234, transmitter model giving ready low 1 cycle after valid and high 5 cycles later -> tx_data sequence 31 32 33 2E 34 0D 0A, 7 valid pulses, busy falls after 7th ready, sat_flag=0.
- Sample 0 -> 30 30 30 2E 30 0D 0A.
- Sample 12000 -> clamps: 39 39 39 2E 39 0D 0A, sat_flag=1; next sample 5 -> 30 30 30 2E 35 0D 0A, sat_flag=0.
- Sample 42 accepted, second sample_valid 3 cycles later -> sample_dropped pulses once, only one frame "004.2\r\n" sent.
- tx_data_ready held low for 100 cycles before first byte -> no tx_data_valid until ready rises, then exactly one pulse per byte, never consecutive.
- start=0 while sending byte index 3 -> next edge: busy=0, tx_data_valid=0, tx_data=00; new sample 987 after release -> full frame "098.7\r\n".
